// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable SRAM.
// MAX_WIDTH bounds be_merge; callers cast their WIDTH-bit words in and out.
package sram_pkg;

   typedef enum logic [1:0] {
      CM_READ_OLD,
      CM_WRITE_FIRST,
      CM_ZERO
   } collision_mode_e;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   localparam int MAX_WIDTH = 1024;

   function automatic logic [MAX_WIDTH-1:0] be_merge(
      input logic [MAX_WIDTH-1:0]   oldWord,
      input logic [MAX_WIDTH-1:0]   newWord,
      input logic [MAX_WIDTH/8-1:0] be
   );
      logic [MAX_WIDTH-1:0] merged;
      merged = oldWord;
      for (int i = 0; i < MAX_WIDTH/8; i++) begin
         if (be[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Request/response bundle of the SRAM; i_/o_ prefixes are from the memory's point of view.
interface sram_dp_be_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 10
);
   logic               i_wren;
   logic [AW-1:0]      i_wr_addr;
   logic [WIDTH-1:0]   i_wr_data;
   logic [WIDTH/8-1:0] i_wr_be;
   logic               i_rden;
   logic [AW-1:0]      i_rd_addr;
   logic [WIDTH-1:0]   o_rd_data;
   logic               o_rd_valid;
   logic               o_init_busy;

   modport master (
      output i_wren, i_wr_addr, i_wr_data, i_wr_be, i_rden, i_rd_addr,
      input  o_rd_data, o_rd_valid, o_init_busy
   );

   modport slave (
      input  i_wren, i_wr_addr, i_wr_data, i_wr_be, i_rden, i_rd_addr,
      output o_rd_data, o_rd_valid, o_init_busy
   );
endinterface

// File: rtl/sram_rd_pipe.sv
// Extra read-result delay stages; each stage's data only moves with its valid,
// so the final stage holds the last returned word between strobes.
module sram_rd_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic w_unused;
         assign w_unused = clk ^ rst;
         assign o_valid  = i_valid;
         assign o_data   = i_data;
      end else begin : g_delay
         logic             r_valid [STAGES];
         logic [WIDTH-1:0] r_data  [STAGES];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < STAGES; s++) begin
                  r_valid[s] <= 1'b0;
                  r_data[s]  <= '0;
               end
            end else begin
               r_valid[0] <= i_valid;
               if (i_valid) r_data[0] <= i_data;
               for (int s = 1; s < STAGES; s++) begin
                  r_valid[s] <= r_valid[s-1];
                  if (r_valid[s-1]) r_data[s] <= r_data[s-1];
               end
            end
         end

         assign o_valid = r_valid[STAGES-1];
         assign o_data  = r_data[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte-enable writes, 1- or 2-cycle reads,
// selectable same-address collision handling and an optional post-reset fill sweep.
module sram_dp_be
   import sram_pkg::*;
#(
   parameter int               WIDTH          = 32,
   parameter int               DEPTH          = 1024,
   parameter int               RD_LATENCY     = 1,
   parameter int               COLLISION_MODE = 0,
   parameter int               INIT_ON_RESET  = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE     = '0
)(
   input logic         clk,
   input logic         rst,
   sram_dp_be_if.slave bus
);

   localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              NB          = WIDTH / 8;
   localparam collision_mode_e CM          = collision_mode_e'(COLLISION_MODE[1:0]);
   localparam logic [AW:0]     DEPTH_C     = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]   LAST_ADDR   = AW'(DEPTH - 1);
   localparam state_e          RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

   state_e           r_state;
   state_e           w_stateNext;
   logic             w_ready;
   logic [AW-1:0]    r_initCnt;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_wrInRange;
   logic             w_rdInRange;
   logic             w_wrOk;
   logic             w_rdOk;
   logic             w_collide;
   logic [WIDTH-1:0] w_oldWord;
   logic [WIDTH-1:0] w_mergedWord;
   logic [WIDTH-1:0] w_rdWord;

   logic             r_s1Valid;
   logic [WIDTH-1:0] r_s1Data;
   logic             w_pipeValid;
   logic [WIDTH-1:0] w_pipeData;

   always_ff @(posedge clk) begin
      if (rst) r_state <= RESET_STATE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      w_ready     = 1'b0;
      case (r_state)
         ST_INIT:  if (r_initCnt == LAST_ADDR) w_stateNext = ST_READY;
         ST_READY: w_ready = 1'b1;
         default:  w_stateNext = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                    r_initCnt <= '0;
      else if (r_state == ST_INIT) r_initCnt <= r_initCnt + 1'b1;
   end

   // A collision needs both requests accepted on the same in-range word.
   always_comb begin
      w_wrInRange  = {1'b0, bus.i_wr_addr} < DEPTH_C;
      w_rdInRange  = {1'b0, bus.i_rd_addr} < DEPTH_C;
      w_wrOk       = w_ready & bus.i_wren & w_wrInRange;
      w_rdOk       = w_ready & bus.i_rden;
      w_collide    = w_wrOk & w_rdOk & (bus.i_wr_addr == bus.i_rd_addr);
      w_oldWord    = w_rdInRange ? r_mem[bus.i_rd_addr] : '0;
      w_mergedWord = WIDTH'(be_merge(MAX_WIDTH'(w_oldWord), MAX_WIDTH'(bus.i_wr_data),
                                     (MAX_WIDTH/8)'(bus.i_wr_be)));
      w_rdWord     = w_oldWord;
      if (w_collide) begin
         case (CM)
            CM_WRITE_FIRST: w_rdWord = w_mergedWord;
            CM_ZERO:        w_rdWord = '0;
            default:        w_rdWord = w_oldWord;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_INIT) begin
            r_mem[r_initCnt] <= INIT_VALUE;
         end else if (w_wrOk) begin
            if (w_collide && (CM == CM_ZERO)) begin
               r_mem[bus.i_wr_addr] <= '0;
            end else begin
               for (int i = 0; i < NB; i++) begin
                  if (bus.i_wr_be[i]) r_mem[bus.i_wr_addr][8*i +: 8] <= bus.i_wr_data[8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_s1Data  <= '0;
      end else begin
         r_s1Valid <= w_rdOk;
         if (w_rdOk) r_s1Data <= w_rdWord;
      end
   end

   sram_rd_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (RD_LATENCY - 1)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_s1Valid),
      .i_data  (r_s1Data),
      .o_valid (w_pipeValid),
      .o_data  (w_pipeData)
   );

   assign bus.o_rd_valid  = w_pipeValid;
   assign bus.o_rd_data   = w_pipeData;
   assign bus.o_init_busy = (r_state == ST_INIT);

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Parametrised simple-dual-port SRAM: one write port with byte enables, one read port with configurable read latency and a read-valid strobe. Same-address read/write collisions resolve according to a selectable mode. An optional post-reset sweep initialises every word to a known value. It is the general-purpose on-chip storage primitive behind FIFOs, buffers and register files.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 1024, number of words; need not be a power of two
RD_LATENCY, 1, cycles from rden to rd_valid; legal values 1 or 2
COLLISION_MODE, 0, 0 = READ_OLD, 1 = WRITE_FIRST, 2 = ZERO (same-address word and read data forced to 0)
INIT_ON_RESET, 1, 1 = sweep-write INIT_VALUE to all words after reset
INIT_VALUE, 0, WIDTH-bit word written by the init sweep

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wren  input  1  write request
wr_addr  input  $clog2(DEPTH)  write address
wr_data  input  WIDTH  write data
wr_be  input  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
rden  input  1  read request
rd_addr  input  $clog2(DEPTH)  read address
rd_data  output  WIDTH  read data; holds last value while rd_valid=0
rd_valid  output  1  one-cycle strobe; rd_data valid this cycle
init_busy  output  1  high while the init sweep runs; requests are ignored

Behaviour:
- Reset (rst=1 at an edge):
  - rd_data=0, rd_valid=0, read pipeline flushed.
  - init counter=0.
  - State becomes ST_INIT if INIT_ON_RESET=1, else ST_READY.
  - Memory contents are not reset directly.
- ST_INIT:
  - Each cycle writes INIT_VALUE to mem[cnt] and increments cnt.
  - After writing DEPTH-1, moves to ST_READY. init_busy=1 for exactly DEPTH cycles after reset deasserts.
  - wren/rden are ignored: no write, no rd_valid.
  - Reset mid-sweep restarts the sweep at address 0.
- ST_READY, write: mem[wr_addr] byte i takes wr_data byte i where wr_be[i]=1; other bytes are unchanged. wren with wr_be=0 is a no-op.
- ST_READY, read: rden in cycle N gives rd_valid=1 and rd_data in cycle N+RD_LATENCY. Back-to-back reads give one result per cycle.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Collision (wren and rden in the same cycle, wr_addr==rd_addr):
  - READ_OLD: read returns the pre-write word; the write completes normally.
  - WRITE_FIRST: read returns the byte-merged new word.
  - ZERO: the stored word becomes all zeros and the read returns 0.
  - Different addresses never interact.
- RD_LATENCY=2: the collision is resolved at stage 1. A write in cycle N+1 to the read address does not alter data already captured for a read issued in cycle N.
- rst has priority over all requests.

Decomposition:
- Package sram_pkg:
  - collision_mode_e enum {CM_READ_OLD, CM_WRITE_FIRST, CM_ZERO}
  - state_e enum {ST_INIT, ST_READY}
  - function be_merge(old, new, be) returning the merged WIDTH word
- Sub-module sram_rd_pipe: valid/data delay line of RD_LATENCY-1 extra stages with synchronous reset. The core array and FSM stay in sram_dp_be.

Test Plan:
- Init: DEPTH=16, INIT_VALUE=32'hA5A5_A5A5, release rst -> init_busy high for exactly 16 cycles; afterwards reads of addresses 0..15 return A5A5_A5A5.
- Byte enables: write 32'h1122_3344 with be=4'hF to addr 3, then 32'hFFFF_FFFF with be=4'b0101 -> read addr 3 returns 32'h11FF_33FF.
- Latency: RD_LATENCY=2, rden at cycles 10, 11, 12 to addrs 0, 1, 2 -> rd_valid at cycles 12, 13, 14 with matching data; rd_data unchanged at cycle 15.
- Collision: addr 5 holds 32'h0000_00AA; same-cycle write 32'h0000_00BB with be=4'hF and read of addr 5:
  - READ_OLD -> rd_data=AA, later read returns BB.
  - WRITE_FIRST -> rd_data=BB.
  - ZERO -> rd_data=0, later read returns 0.
- Reset mid-init: assert rst at sweep cycle 7 for one cycle -> init_busy stays high 16 further cycles; rden during the sweep yields no rd_valid.
- Out of range: DEPTH=12, write 32'h1234 to addr 13, then read addr 13 -> rd_valid=1, rd_data=0; addrs 0..11 unchanged.
